rr_ex_stage: RTL and testbench
==============================

Name: rr_ex_stage

Overview:
- Pipeline register between register-read (RR) and execute (EX) in the 5-stage MIPS core.
- Captures operands, immediate and control for the instruction entering EX.
- Generates the registered Forwarding_control_1/2 codes that drive the EX-stage operand forwarding muxes.
- Detects load-use hazards and inserts bubbles. Applies a WB-to-RR bypass for same-cycle register-file writes.

Parameters:
- CTRL_W, 12, width of the opaque EX/MM/WB control bundle passed through unchanged.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- stall_in  in  1  global freeze (memory wait); holds all state
- flush  in  1  branch taken; kill the RR instruction
- rr_valid  in  1  RR holds a real instruction
- rr_rs, rr_rt  in  REG_AW  source register numbers
- rr_uses_rs, rr_uses_rt  in  1  source actually read
- rr_dest  in  REG_AW  destination register
- rr_reg_write, rr_mem_read  in  1  writes register / is a load
- rr_read_data_1, rr_read_data_2  in  32  register-file outputs
- rr_imm  in  32  sign/zero-extended immediate
- rr_ctrl  in  CTRL_W  downstream control bundle
- wb_reg_write  in  1  WB writes the register file this cycle
- wb_dest  in  REG_AW  WB destination
- wb_data  in  32  WB write data
- ex_valid  out  1  EX holds a real instruction
- Read_Data_1_rr_ex, Read_Data_2_rr_ex  out  32  registered operands
- imm_rr_ex  out  32  registered immediate
- ctrl_rr_ex  out  CTRL_W  registered control
- dest_rr_ex  out  REG_AW  registered destination
- reg_write_rr_ex, mem_read_rr_ex  out  1  registered flags
- Forwarding_control_1, Forwarding_control_2  out  2  00 regfile, 01 ex_mm, 10 mm_wb
- load_use_stall  out  1  combinational; RR and IF must hold

Behaviour:
- Reset (reset_n=0 at a rising edge): all registered outputs go to 0, including ex_valid=0 and forwarding codes 00. The MM shadow is cleared.
- Internal MM shadow (mm_valid, mm_dest, mm_reg_write) holds the instruction now in EX/MM. On each non-stalled edge it loads the current EX fields.
- Match rule for a source s (rs or rt):
  - usable(s) = uses_s AND s != 0.
  - ex_hit = ex_valid & reg_write_rr_ex & dest_rr_ex == s.
  - mm_hit = mm_valid & mm_reg_write & mm_dest == s.
- Hazard: hazard = rr_valid & ex_valid & mem_read_rr_ex & ((usable(rs) & ex_hit(rs)) | (usable(rt) & ex_hit(rt))).
- load_use_stall = hazard & ~flush.
- Next forwarding code per source: 01 if usable & ex_hit; else 10 if usable & mm_hit; else 00. ex_hit has priority over mm_hit (younger producer wins).
- Operand capture: if wb_reg_write & wb_dest != 0 & wb_dest == rs, capture wb_data instead of rr_read_data_1. rt uses the same rule for operand 2. The forwarding code still overrides the captured value in EX.
- Edge priority, highest first:
  - reset
  - stall_in: hold everything, including the shadow
  - flush: bubble into EX, shadow advances
  - load_use_stall: bubble into EX, shadow advances
  - otherwise: load RR fields
- Bubble: ex_valid=0, reg_write_rr_ex=0, mem_read_rr_ex=0, forwarding codes 00. Data fields are don't-care and are held.
- Latency: one cycle from RR to EX. Forwarding codes are valid in the same cycle as their operands.
- Stall and flush in the same cycle: stall_in wins; the flush must be re-presented.
- A load-use stall lasts exactly one cycle. The next cycle the load is in MM, giving code 10.
- rr_valid=0: treated as a bubble, with no hazard raised.

Decomposition:
- Package mips_pipe_pkg holds FWD_REGFILE=2'b00, FWD_EX_MM=2'b01, FWD_MM_WB=2'b10, REG_ZERO, CTRL_W.
- Sub-module forwarding_select (combinational) takes one source, the EX and MM producer fields and uses_s, and returns the 2-bit code and ex_hit. It is instantiated twice, once for rs and once for rt.
- Registers and hazard logic stay in rr_ex_stage.

Test Plan:
- Reset: reset_n=0 for 2 cycles with random inputs -> all outputs 0; ex_valid=0; codes 00.
- EX forward: add $3 in EX, then RR sub using rs=$3, rt=$4 -> next cycle Forwarding_control_1=01, Forwarding_control_2=00.
- MM forward and priority:
  - $5 written by the MM-shadow instruction, RR uses rt=$5 -> code 10.
  - Both EX and MM write $5 -> code 01.
- Load-use: lw $2 in EX, RR uses rs=$2 -> load_use_stall=1 for 1 cycle; EX bubble (ex_valid=0); the following cycle the instruction enters EX with Forwarding_control_1=10.
- Register zero and WB bypass:
  - RR rs=$0 while EX writes $0 -> code 00.
  - wb_dest=$7, wb_data=32'hDEADBEEF, RR rs=$7, stale regfile value 0 -> Read_Data_1_rr_ex=32'hDEADBEEF.
- Control interplay:
  - flush with a load-use hazard -> load_use_stall=0, bubble.
  - stall_in=1 for 3 cycles -> outputs unchanged.
  - reset_n=0 mid-stall -> all outputs cleared next edge.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
//   Shared constants and types for the 5-stage MIPS pipeline registers.
//   - CTRL_W      : default width of the opaque EX/MM/WB control bundle
//   - REG_ZERO    : architectural register $0 (hard-wired zero, never a producer)
//   - FWD_*       : encodings of the EX-stage operand forwarding mux select
//   - edge_act_e  : what a pipeline register does on a clock edge
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

  localparam int CTRL_W   = 12;
  localparam int REG_ZERO = 0;

  localparam logic [1:0] FWD_REGFILE = 2'b00;  // use the captured operand
  localparam logic [1:0] FWD_EX_MM   = 2'b01;  // younger producer, now in EX/MM
  localparam logic [1:0] FWD_MM_WB   = 2'b10;  // older producer, now in MM/WB

  typedef enum logic [1:0] {
    ACT_HOLD,    // freeze every register, shadow included
    ACT_BUBBLE,  // kill the slot entering EX, shadow still advances
    ACT_LOAD     // accept the RR instruction
  } edge_act_e;

endpackage

// File: rtl/forwarding_select.sv
// -----------------------------------------------------------------------------
// forwarding_select
//   Combinational forwarding decision for one source operand of the
//   instruction in RR, looking at the producers currently in EX and in MM.
//   Ports:
//     src, uses                   source register number and "actually read"
//     ex_valid/ex_reg_write/ex_dest  producer now in EX
//     mm_valid/mm_reg_write/mm_dest  producer now in MM
//     code                        next forwarding select for this operand
//     ex_hit                      source is read, non-zero and produced in EX
// -----------------------------------------------------------------------------
module forwarding_select
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              uses,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              mm_valid,
  input  logic              mm_reg_write,
  input  logic [REG_AW-1:0] mm_dest,
  output logic [1:0]        code,
  output logic              ex_hit
);

  logic usable;
  logic mm_hit;

  // $0 reads as zero regardless of any in-flight write to it.
  assign usable = uses && (src != REG_AW'(REG_ZERO));
  assign ex_hit = usable && ex_valid && ex_reg_write && (ex_dest == src);
  assign mm_hit = usable && mm_valid && mm_reg_write && (mm_dest == src);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    code = FWD_REGFILE;
    // The EX producer is younger than the MM one, so it wins.
    if (ex_hit)      code = FWD_EX_MM;
    else if (mm_hit) code = FWD_MM_WB;
  end

endmodule

// File: rtl/rr_ex_stage.sv
// -----------------------------------------------------------------------------
// rr_ex_stage
//   RR -> EX pipeline register of the 5-stage MIPS core.
//   - Captures operands (with WB->RR bypass), immediate, destination, flags
//     and the opaque downstream control bundle.
//   - Registers the Forwarding_control_1/2 selects for the EX operand muxes,
//     aligned with the operands they steer.
//   - Detects load-use hazards (load in EX feeding RR) and inserts a bubble.
//   - Keeps a small shadow of the instruction now in EX/MM for MM forwarding.
//   Ports:
//     clk, reset_n          clock, synchronous active-low reset
//     stall_in, flush       global freeze / kill the RR instruction
//     rr_*                  instruction presented by register-read
//     wb_reg_write/dest/data  register-file write happening this cycle
//     ex_valid, *_rr_ex     registered EX-stage fields
//     Forwarding_control_1/2  registered forwarding selects (rs / rt)
//     load_use_stall        combinational; RR and IF must hold
// -----------------------------------------------------------------------------
module rr_ex_stage
  import mips_pipe_pkg::FWD_REGFILE, mips_pipe_pkg::edge_act_e,
         mips_pipe_pkg::ACT_HOLD, mips_pipe_pkg::ACT_BUBBLE,
         mips_pipe_pkg::ACT_LOAD, mips_pipe_pkg::REG_ZERO;
#(
  parameter int CTRL_W = mips_pipe_pkg::CTRL_W,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              rr_valid,
  input  logic [REG_AW-1:0] rr_rs,
  input  logic [REG_AW-1:0] rr_rt,
  input  logic              rr_uses_rs,
  input  logic              rr_uses_rt,
  input  logic [REG_AW-1:0] rr_dest,
  input  logic              rr_reg_write,
  input  logic              rr_mem_read,
  input  logic [31:0]       rr_read_data_1,
  input  logic [31:0]       rr_read_data_2,
  input  logic [31:0]       rr_imm,
  input  logic [CTRL_W-1:0] rr_ctrl,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [31:0]       wb_data,
  output logic              ex_valid,
  output logic [31:0]       Read_Data_1_rr_ex,
  output logic [31:0]       Read_Data_2_rr_ex,
  output logic [31:0]       imm_rr_ex,
  output logic [CTRL_W-1:0] ctrl_rr_ex,
  output logic [REG_AW-1:0] dest_rr_ex,
  output logic              reg_write_rr_ex,
  output logic              mem_read_rr_ex,
  output logic [1:0]        Forwarding_control_1,
  output logic [1:0]        Forwarding_control_2,
  output logic              load_use_stall
);

  // Shadow of the instruction currently in EX/MM.
  logic              mm_valid;
  logic [REG_AW-1:0] mm_dest;
  logic              mm_reg_write;

  logic [1:0]  fwd_rs_next;
  logic [1:0]  fwd_rt_next;
  logic        ex_hit_rs;
  logic        ex_hit_rt;
  logic        hazard;
  logic        wb_hit_rs;
  logic        wb_hit_rt;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  edge_act_e   act;

  forwarding_select #(.REG_AW(REG_AW)) u_fwd_rs (
    .src          (rr_rs),
    .uses         (rr_uses_rs),
    .ex_valid     (ex_valid),
    .ex_reg_write (reg_write_rr_ex),
    .ex_dest      (dest_rr_ex),
    .mm_valid     (mm_valid),
    .mm_reg_write (mm_reg_write),
    .mm_dest      (mm_dest),
    .code         (fwd_rs_next),
    .ex_hit       (ex_hit_rs)
  );

  forwarding_select #(.REG_AW(REG_AW)) u_fwd_rt (
    .src          (rr_rt),
    .uses         (rr_uses_rt),
    .ex_valid     (ex_valid),
    .ex_reg_write (reg_write_rr_ex),
    .ex_dest      (dest_rr_ex),
    .mm_valid     (mm_valid),
    .mm_reg_write (mm_reg_write),
    .mm_dest      (mm_dest),
    .code         (fwd_rt_next),
    .ex_hit       (ex_hit_rt)
  );

  // A load in EX has no data until MM; a dependent RR instruction waits one
  // cycle and then picks the value up through the MM/WB forward.
  assign hazard         = rr_valid && ex_valid && mem_read_rr_ex &&
                          (ex_hit_rs || ex_hit_rt);
  assign load_use_stall = hazard && !flush;

  // The register file is written at the end of this cycle, so its read port
  // still shows the old value; take the WB data directly instead.
  assign wb_hit_rs = wb_reg_write && (wb_dest != REG_AW'(REG_ZERO)) &&
                     (wb_dest == rr_rs);
  assign wb_hit_rt = wb_reg_write && (wb_dest != REG_AW'(REG_ZERO)) &&
                     (wb_dest == rr_rt);
  assign operand_1 = wb_hit_rs ? wb_data : rr_read_data_1;
  assign operand_2 = wb_hit_rt ? wb_data : rr_read_data_2;

  // Edge action in priority order; stall beats flush, so a flush arriving
  // during a stall must be re-presented by its source.
  always_comb begin
    act = ACT_LOAD;
    if (stall_in)                 act = ACT_HOLD;
    else if (flush)               act = ACT_BUBBLE;
    else if (hazard || !rr_valid) act = ACT_BUBBLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid             <= 1'b0;
      Read_Data_1_rr_ex    <= '0;
      Read_Data_2_rr_ex    <= '0;
      imm_rr_ex            <= '0;
      ctrl_rr_ex           <= '0;
      dest_rr_ex           <= '0;
      reg_write_rr_ex      <= 1'b0;
      mem_read_rr_ex       <= 1'b0;
      Forwarding_control_1 <= FWD_REGFILE;
      Forwarding_control_2 <= FWD_REGFILE;
      mm_valid             <= 1'b0;
      mm_dest              <= '0;
      mm_reg_write         <= 1'b0;
    end else begin
      case (act)
        ACT_BUBBLE: begin
          mm_valid             <= ex_valid;
          mm_dest              <= dest_rr_ex;
          mm_reg_write         <= reg_write_rr_ex;
          // Data fields are don't-care in a bubble and simply hold.
          ex_valid             <= 1'b0;
          reg_write_rr_ex      <= 1'b0;
          mem_read_rr_ex       <= 1'b0;
          Forwarding_control_1 <= FWD_REGFILE;
          Forwarding_control_2 <= FWD_REGFILE;
        end
        ACT_LOAD: begin
          mm_valid             <= ex_valid;
          mm_dest              <= dest_rr_ex;
          mm_reg_write         <= reg_write_rr_ex;
          ex_valid             <= 1'b1;
          Read_Data_1_rr_ex    <= operand_1;
          Read_Data_2_rr_ex    <= operand_2;
          imm_rr_ex            <= rr_imm;
          ctrl_rr_ex           <= rr_ctrl;
          dest_rr_ex           <= rr_dest;
          reg_write_rr_ex      <= rr_reg_write;
          mem_read_rr_ex       <= rr_mem_read;
          Forwarding_control_1 <= fwd_rs_next;
          Forwarding_control_2 <= fwd_rt_next;
        end
        default: ; // ACT_HOLD: everything keeps its value
      endcase
    end
  end

endmodule

// File: tb/tb_rr_ex_stage.sv
module tb_rr_ex_stage;

  localparam int CTRL_W = 12;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              stall_in;
  logic              flush;
  logic              rr_valid;
  logic [REG_AW-1:0] rr_rs;
  logic [REG_AW-1:0] rr_rt;
  logic              rr_uses_rs;
  logic              rr_uses_rt;
  logic [REG_AW-1:0] rr_dest;
  logic              rr_reg_write;
  logic              rr_mem_read;
  logic [31:0]       rr_read_data_1;
  logic [31:0]       rr_read_data_2;
  logic [31:0]       rr_imm;
  logic [CTRL_W-1:0] rr_ctrl;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_dest;
  logic [31:0]       wb_data;
  logic              ex_valid;
  logic [31:0]       Read_Data_1_rr_ex;
  logic [31:0]       Read_Data_2_rr_ex;
  logic [31:0]       imm_rr_ex;
  logic [CTRL_W-1:0] ctrl_rr_ex;
  logic [REG_AW-1:0] dest_rr_ex;
  logic              reg_write_rr_ex;
  logic              mem_read_rr_ex;
  logic [1:0]        Forwarding_control_1;
  logic [1:0]        Forwarding_control_2;
  logic              load_use_stall;

  int n_vec = 0;
  int n_err = 0;

  rr_ex_stage #(.CTRL_W(CTRL_W), .REG_AW(REG_AW)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .stall_in             (stall_in),
    .flush                (flush),
    .rr_valid             (rr_valid),
    .rr_rs                (rr_rs),
    .rr_rt                (rr_rt),
    .rr_uses_rs           (rr_uses_rs),
    .rr_uses_rt           (rr_uses_rt),
    .rr_dest              (rr_dest),
    .rr_reg_write         (rr_reg_write),
    .rr_mem_read          (rr_mem_read),
    .rr_read_data_1       (rr_read_data_1),
    .rr_read_data_2       (rr_read_data_2),
    .rr_imm               (rr_imm),
    .rr_ctrl              (rr_ctrl),
    .wb_reg_write         (wb_reg_write),
    .wb_dest              (wb_dest),
    .wb_data              (wb_data),
    .ex_valid             (ex_valid),
    .Read_Data_1_rr_ex    (Read_Data_1_rr_ex),
    .Read_Data_2_rr_ex    (Read_Data_2_rr_ex),
    .imm_rr_ex            (imm_rr_ex),
    .ctrl_rr_ex           (ctrl_rr_ex),
    .dest_rr_ex           (dest_rr_ex),
    .reg_write_rr_ex      (reg_write_rr_ex),
    .mem_read_rr_ex       (mem_read_rr_ex),
    .Forwarding_control_1 (Forwarding_control_1),
    .Forwarding_control_2 (Forwarding_control_2),
    .load_use_stall       (load_use_stall)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rr(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt,
                          input logic [4:0] dest, input logic rw, input logic mr,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [11:0] ctrl);
    rr_valid       = v;
    rr_rs          = rs;
    rr_uses_rs     = urs;
    rr_rt          = rt;
    rr_uses_rt     = urt;
    rr_dest        = dest;
    rr_reg_write   = rw;
    rr_mem_read    = mr;
    rr_read_data_1 = d1;
    rr_read_data_2 = d2;
    rr_imm         = imm;
    rr_ctrl        = ctrl;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n        = 1'b0;
    stall_in       = 1'($urandom);
    flush          = 1'($urandom);
    drive_rr(1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom),
             1'b1, 1'b1, $urandom, $urandom, $urandom, 12'($urandom));
    wb_reg_write   = 1'b1;
    wb_dest        = 5'($urandom);
    wb_data        = $urandom;
    step();
    step();
    n_vec++;
    if ({ex_valid, reg_write_rr_ex, mem_read_rr_ex} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got %b exp 000", {ex_valid, reg_write_rr_ex, mem_read_rr_ex});
    end
    n_vec++;
    if ({Forwarding_control_1, Forwarding_control_2} !== 4'b0000) begin
      n_err++; $display("FAIL reset_fwd got %b exp 0000", {Forwarding_control_1, Forwarding_control_2});
    end
    n_vec++;
    if ({Read_Data_1_rr_ex, Read_Data_2_rr_ex, imm_rr_ex} !== 96'd0) begin
      n_err++; $display("FAIL reset_data got %h %h %h exp 0", Read_Data_1_rr_ex, Read_Data_2_rr_ex, imm_rr_ex);
    end
    n_vec++;
    if ({ctrl_rr_ex, dest_rr_ex} !== 17'd0) begin
      n_err++; $display("FAIL reset_ctrl_dest got %h %h exp 0", ctrl_rr_ex, dest_rr_ex);
    end
    n_vec++;
    if (load_use_stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall got %b exp 0", load_use_stall);
    end
    stall_in     = 1'b0;
    flush        = 1'b0;
    wb_reg_write = 1'b0;
    wb_dest      = '0;
    wb_data      = '0;
    drive_rr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 0, 0, 12'h0);
    reset_n = 1'b1;
    step();
  endtask

  // add $3 in EX, then sub reading $3/$4.
  task automatic test_ex_forward();
    drive_rr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 32'h1, 32'h2, 32'h0, 12'h001);
    step();
    drive_rr(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 32'h11, 32'h22, 32'h33, 12'h002);
    #1;
    n_vec++;
    if (load_use_stall !== 1'b0) begin
      n_err++; $display("FAIL exfwd_no_stall got %b exp 0", load_use_stall);
    end
    step();
    n_vec++;
    if ({ex_valid, Forwarding_control_1, Forwarding_control_2} !== 5'b1_01_00) begin
      n_err++; $display("FAIL exfwd_codes got %b exp 10100", {ex_valid, Forwarding_control_1, Forwarding_control_2});
    end
    n_vec++;
    if ({Read_Data_1_rr_ex, Read_Data_2_rr_ex, imm_rr_ex} !== {32'h11, 32'h22, 32'h33}) begin
      n_err++; $display("FAIL exfwd_data got %h %h %h exp 11 22 33", Read_Data_1_rr_ex, Read_Data_2_rr_ex, imm_rr_ex);
    end
    n_vec++;
    if ({dest_rr_ex, reg_write_rr_ex, mem_read_rr_ex, ctrl_rr_ex} !== {5'd6, 1'b1, 1'b0, 12'h002}) begin
      n_err++; $display("FAIL exfwd_fields got %0d %b %b %h exp 6 1 0 002", dest_rr_ex, reg_write_rr_ex, mem_read_rr_ex, ctrl_rr_ex);
    end
  endtask

  // $5 produced by the MM instruction, then by both EX and MM.
  task automatic test_mm_forward();
    drive_rr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 0, 0, 0, 12'h0);  // X -> $5
    step();
    drive_rr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 0, 0, 0, 12'h0);  // Y -> $9
    step();
    drive_rr(1'b1, 5'd8, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 0, 0, 0, 12'h0);  // Z reads $8,$5 -> $5
    step();
    n_vec++;
    if ({Forwarding_control_1, Forwarding_control_2} !== 4'b00_10) begin
      n_err++; $display("FAIL mmfwd_codes got %b exp 0010", {Forwarding_control_1, Forwarding_control_2});
    end
    drive_rr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 0, 0, 0, 12'h0);  // P -> $5
    step();
    drive_rr(1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 5'd13, 1'b0, 1'b0, 0, 0, 0, 12'h0); // Q reads $0,$5
    step();
    n_vec++;
    if ({Forwarding_control_1, Forwarding_control_2} !== 4'b00_01) begin
      n_err++; $display("FAIL priority_codes got %b exp 0001", {Forwarding_control_1, Forwarding_control_2});
    end
  endtask

  // lw $2 in EX, dependent add in RR.
  task automatic test_load_use();
    drive_rr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 0, 0, 32'h4, 12'h0);
    step();
    drive_rr(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 32'hA, 32'hB, 0, 12'h0);
    #1;
    n_vec++;
    if (load_use_stall !== 1'b1) begin
      n_err++; $display("FAIL lu_stall_raised got %b exp 1", load_use_stall);
    end
    step();
    n_vec++;
    if ({ex_valid, reg_write_rr_ex, mem_read_rr_ex, Forwarding_control_1, Forwarding_control_2} !== 7'b0) begin
      n_err++; $display("FAIL lu_bubble got %b exp 0000000", {ex_valid, reg_write_rr_ex, mem_read_rr_ex, Forwarding_control_1, Forwarding_control_2});
    end
    n_vec++;
    if (load_use_stall !== 1'b0) begin
      n_err++; $display("FAIL lu_stall_one_cycle got %b exp 0", load_use_stall);
    end
    step();
    n_vec++;
    if ({ex_valid, Forwarding_control_1, Forwarding_control_2} !== 5'b1_10_00) begin
      n_err++; $display("FAIL lu_reissue_codes got %b exp 11000", {ex_valid, Forwarding_control_1, Forwarding_control_2});
    end
    n_vec++;
    if ({dest_rr_ex, reg_write_rr_ex, mem_read_rr_ex} !== {5'd4, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL lu_reissue_fields got %0d %b %b exp 4 1 0", dest_rr_ex, reg_write_rr_ex, mem_read_rr_ex);
    end
  endtask

  task automatic test_zero_and_bypass();
    drive_rr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 0, 0, 12'h0);  // writes $0
    step();
    // Reads $0 while EX writes $0; WB also "writes" $0 and must not bypass.
    drive_rr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b0, 1'b0, 32'h55, 32'h66, 0, 12'h0);
    wb_reg_write = 1'b1;
    wb_dest      = 5'd0;
    wb_data      = 32'hFFFF_FFFF;
    step();
    n_vec++;
    if ({Forwarding_control_1, Forwarding_control_2} !== 4'b0000) begin
      n_err++; $display("FAIL zero_codes got %b exp 0000", {Forwarding_control_1, Forwarding_control_2});
    end
    n_vec++;
    if ({Read_Data_1_rr_ex, Read_Data_2_rr_ex} !== {32'h55, 32'h66}) begin
      n_err++; $display("FAIL zero_no_bypass got %h %h exp 55 66", Read_Data_1_rr_ex, Read_Data_2_rr_ex);
    end
    drive_rr(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd14, 1'b0, 1'b0, 32'h0, 32'h1234, 0, 12'h0);
    wb_dest = 5'd7;
    wb_data = 32'hDEAD_BEEF;
    step();
    n_vec++;
    if ({Read_Data_1_rr_ex, Read_Data_2_rr_ex} !== {32'hDEAD_BEEF, 32'h1234}) begin
      n_err++; $display("FAIL wb_bypass got %h %h exp deadbeef 00001234", Read_Data_1_rr_ex, Read_Data_2_rr_ex);
    end
    n_vec++;
    if ({Forwarding_control_1, Forwarding_control_2} !== 4'b0000) begin
      n_err++; $display("FAIL wb_bypass_codes got %b exp 0000", {Forwarding_control_1, Forwarding_control_2});
    end
    wb_reg_write = 1'b0;
    wb_dest      = '0;
    wb_data      = '0;
  endtask

  task automatic test_flush_and_invalid();
    drive_rr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 0, 0, 0, 12'h0);  // lw $2
    step();
    drive_rr(1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 0, 0, 0, 12'h0);
    #1;
    n_vec++;
    if (load_use_stall !== 1'b0) begin
      n_err++; $display("FAIL invalid_no_hazard got %b exp 0", load_use_stall);
    end
    rr_valid = 1'b1;
    flush    = 1'b1;
    #1;
    n_vec++;
    if (load_use_stall !== 1'b0) begin
      n_err++; $display("FAIL flush_masks_stall got %b exp 0", load_use_stall);
    end
    step();
    n_vec++;
    if ({ex_valid, reg_write_rr_ex, mem_read_rr_ex, Forwarding_control_1, Forwarding_control_2} !== 7'b0) begin
      n_err++; $display("FAIL flush_bubble got %b exp 0000000", {ex_valid, reg_write_rr_ex, mem_read_rr_ex, Forwarding_control_1, Forwarding_control_2});
    end
    flush = 1'b0;
  endtask

  task automatic test_stall_hold();
    // EX holds a bubble, MM holds lw $2: reading $2 gives the MM forward.
    drive_rr(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0,
             32'h1111, 32'h2222, 32'hABCD, 12'h5A5);
    step();
    n_vec++;
    if ({ex_valid, Forwarding_control_1, dest_rr_ex} !== {1'b1, 2'b10, 5'd11}) begin
      n_err++; $display("FAIL pre_stall got %b %b %0d exp 1 10 11", ex_valid, Forwarding_control_1, dest_rr_ex);
    end
    stall_in = 1'b1;
    drive_rr(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0,
             32'h9999, 32'h8888, 32'h7777, 12'h123);
    for (int c = 0; c < 3; c++) begin
      flush = (c == 1);
      step();
      n_vec++;
      if ({ex_valid, reg_write_rr_ex, mem_read_rr_ex, Forwarding_control_1, Forwarding_control_2, dest_rr_ex}
          !== {1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 5'd11}) begin
        n_err++; $display("FAIL stall_hold_flags[%0d] got %b %b %b %b %b %0d exp 1 1 0 10 00 11", c,
                          ex_valid, reg_write_rr_ex, mem_read_rr_ex, Forwarding_control_1, Forwarding_control_2, dest_rr_ex);
      end
      n_vec++;
      if ({Read_Data_1_rr_ex, Read_Data_2_rr_ex, imm_rr_ex, ctrl_rr_ex}
          !== {32'h1111, 32'h2222, 32'hABCD, 12'h5A5}) begin
        n_err++; $display("FAIL stall_hold_data[%0d] got %h %h %h %h exp 1111 2222 abcd 5a5", c,
                          Read_Data_1_rr_ex, Read_Data_2_rr_ex, imm_rr_ex, ctrl_rr_ex);
      end
    end
    stall_in = 1'b0;
    flush    = 1'b0;
    step();
    n_vec++;
    if ({ex_valid, Forwarding_control_1, dest_rr_ex, Read_Data_1_rr_ex} !== {1'b1, 2'b01, 5'd20, 32'h9999}) begin
      n_err++; $display("FAIL post_stall got %b %b %0d %h exp 1 01 20 9999", ex_valid, Forwarding_control_1, dest_rr_ex, Read_Data_1_rr_ex);
    end
    drive_rr(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd21, 1'b0, 1'b0, 0, 0, 0, 12'h0);
    step();
    n_vec++;
    if (Forwarding_control_1 !== 2'b10) begin
      n_err++; $display("FAIL post_stall_mm got %b exp 10", Forwarding_control_1);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_rr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd22, 1'b1, 1'b1, 32'h5, 32'h6, 32'h7, 12'hFFF);
    step();
    stall_in = 1'b1;
    step();
    reset_n = 1'b0;
    step();
    n_vec++;
    if ({ex_valid, reg_write_rr_ex, mem_read_rr_ex, Forwarding_control_1, Forwarding_control_2} !== 7'b0) begin
      n_err++; $display("FAIL midstall_reset_flags got %b exp 0000000", {ex_valid, reg_write_rr_ex, mem_read_rr_ex, Forwarding_control_1, Forwarding_control_2});
    end
    n_vec++;
    if ({Read_Data_1_rr_ex, Read_Data_2_rr_ex, imm_rr_ex, ctrl_rr_ex, dest_rr_ex} !== 113'd0) begin
      n_err++; $display("FAIL midstall_reset_data got %h %h %h %h %0d exp 0", Read_Data_1_rr_ex, Read_Data_2_rr_ex, imm_rr_ex, ctrl_rr_ex, dest_rr_ex);
    end
    reset_n  = 1'b1;
    stall_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_mm_forward();
    test_load_use();
    test_zero_and_bypass();
    test_flush_and_invalid();
    test_stall_hold();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
